// File: rtl/lcd_pixel_packer.sv
// lcd_pixel_packer
//   Encodes one RGB888 pixel (or palette index) per cycle according to the
//   lcdbpp mode and packs successive encoded pixels into OUT_W-bit words for
//   the LCD output FIFO. Pixels arrive and words leave over valid/ready
//   handshakes. pix_last flushes a partially filled word at line end.
//
// Parameters
//   OUT_W      output word width, 32 or 64
//   MSB_FIRST  0: first pixel of a word in the LSBs, 1: first pixel in the MSBs
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   lcdbpp[2:0]             encoding mode, sampled on the first pixel of a word
//   pix_in[23:0]            R=[23:16] G=[15:8] B=[7:0] or palette index in LSBs
//   pix_valid/pix_ready     input handshake
//   pix_last                last pixel of a line (qualified by pix_valid)
//   word_out[OUT_W-1:0]     packed word
//   word_valid/word_ready   output handshake
//   word_last               word holds the last pixel of a line
//   mode_q[2:0]             mode latched for the word under assembly
module lcd_pixel_packer #(
  parameter int OUT_W     = 32,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       lcdbpp,
  input  logic [23:0]      pix_in,
  input  logic             pix_valid,
  input  logic             pix_last,
  output logic             pix_ready,
  output logic [OUT_W-1:0] word_out,
  output logic             word_valid,
  output logic             word_last,
  input  logic             word_ready,
  output logic [2:0]       mode_q
);

  localparam int CNT_W = $clog2(OUT_W);

  logic [OUT_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  // Slot width in bits for each mode.
  function automatic int slot_w(input logic [2:0] mode);
    case (mode)
      3'b000:  slot_w = 1;
      3'b001:  slot_w = 2;
      3'b010:  slot_w = 4;
      3'b011:  slot_w = 8;
      3'b101:  slot_w = 32;
      default: slot_w = 16;
    endcase
  endfunction

  // Encoded pixel, right-justified and zero-extended to the word width.
  function automatic logic [OUT_W-1:0] encode(input logic [2:0] mode,
                                              input logic [23:0] p);
    logic [31:0] e;
    case (mode)
      3'b000:  e = {31'd0, p[0]};
      3'b001:  e = {30'd0, p[1:0]};
      3'b010:  e = {28'd0, p[3:0]};
      3'b011:  e = {24'd0, p[7:0]};
      3'b100:  e = {16'd0, p[10], p[23:19], p[15:11], p[7:3]};
      3'b101:  e = {8'h00, p};
      3'b110:  e = {16'd0, p[23:19], p[15:10], p[7:3]};
      default: e = {20'd0, p[23:20], p[15:12], p[7:4]};
    endcase
    encode        = '0;
    encode[31:0]  = e;
  endfunction

  // Stage p0: encode the incoming pixel and merge it into the accumulator.
  logic [2:0]       mode_p0;
  logic [OUT_W-1:0] merged_p0;
  logic             acc_p0;
  logic             done_p0;
  int               s_w_p0;
  int               ppw_p0;
  int               sh_p0;

  assign pix_ready = !word_valid || word_ready;

  always_comb begin
    // A new word takes its mode straight from lcdbpp; later pixels reuse mode_q.
    mode_p0   = (cnt == '0) ? lcdbpp : mode_q;
    s_w_p0    = slot_w(mode_p0);
    ppw_p0    = OUT_W / s_w_p0;
    sh_p0     = MSB_FIRST ? (OUT_W - (int'(cnt) + 1) * s_w_p0) : (int'(cnt) * s_w_p0);
    merged_p0 = acc | (encode(mode_p0, pix_in) << sh_p0);
    acc_p0    = pix_valid && pix_ready;
    done_p0   = acc_p0 && ((int'(cnt) == ppw_p0 - 1) || pix_last);
  end

  // Stage p1: accumulator update and output word register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      mode_q     <= 3'b000;
      word_out   <= '0;
      word_valid <= 1'b0;
      word_last  <= 1'b0;
    end else begin
      if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
      if (acc_p0) begin
        if (cnt == '0) begin
          mode_q <= lcdbpp;
        end
        if (done_p0) begin
          // A completing pixel overrides the clear above, so a word can be
          // replaced in the same cycle it is consumed.
          word_out   <= merged_p0;
          word_valid <= 1'b1;
          word_last  <= pix_last;
          acc        <= '0;
          cnt        <= '0;
        end else begin
          acc <= merged_p0;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/lcd_pixel_packer.md
Name: lcd_pixel_packer

Overview:
- Parametrised successor to the combinational TFT/STN data encoder.
- Accepts one 24-bit RGB888 pixel (or palette index) per cycle over a valid/ready handshake.
- Encodes each pixel per the 3-bit lcdbpp mode and packs successive encoded pixels into OUT_W-bit words for the LCD DMA/output FIFO.
- Sits between the pixel pipeline and the LCD output FIFO; supports line-end flush, selectable pixel order and backpressure.

Parameters:
- OUT_W, 32, output word width; legal values 32 or 64.
- MSB_FIRST, 0, 0 = first pixel of a word in the LSBs; 1 = first pixel in the MSBs.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- lcdbpp  in  3  encoding mode, latched per word (see Behaviour).
- pix_in  in  24  pixel: R=[23:16], G=[15:8], B=[7:0]; palette index in the LSBs for 1/2/4/8 bpp.
- pix_valid  in  1  pix_in valid.
- pix_last  in  1  last pixel of a line; qualified by pix_valid.
- pix_ready  out  1  packer can accept a pixel.
- word_out  out  OUT_W  packed word.
- word_valid  out  1  word_out valid.
- word_last  out  1  word contains the last pixel of a line.
- word_ready  in  1  downstream accepts the word.
- mode_q  out  3  mode currently latched for the word under assembly.

Behaviour:
- Accept: pixel accepted when pix_valid && pix_ready.
- pix_ready = !word_valid || word_ready (combinational). The packer stalls whenever the output register is held.
- Encoding by lcdbpp, with slot width S in brackets:
  - 000 (S=1): pix_in[0].
  - 001 (S=2): pix_in[1:0].
  - 010 (S=4): pix_in[3:0].
  - 011 (S=8): pix_in[7:0].
  - 100 (S=16): {G[2], R[7:3], G[7:3], B[7:3]}.
  - 101 (S=32): {8'h00, R, G, B}.
  - 110 (S=16): {R[7:3], G[7:2], B[7:3]}.
  - 111 (S=16): {4'h0, R[7:4], G[7:4], B[7:4]}.
- Pixels per word: PPW = OUT_W/S.
  - OUT_W=32: 32/16/8/4/2/1/2/2 for modes 000..111.
  - OUT_W=64 doubles each value.
- Slot placement:
  - MSB_FIRST=0: pixel k (0-based within the word) occupies bits [k*S+S-1 : k*S].
  - MSB_FIRST=1: pixel k occupies bits [OUT_W-1-k*S : OUT_W-k*S-S].
- State: accumulator acc (OUT_W), slot counter cnt (0..PPW-1), latched mode mode_q.
- Mode latch: mode_q loads lcdbpp on the accepted pixel when cnt==0. It is held until that word is emitted. lcdbpp changes mid-word are ignored. mode_q drives the encoding for all later pixels of the word.
- Word completion: an accepted pixel completes the word if cnt==PPW-1 or pix_last==1. On the same edge:
  - word_out <= acc with this pixel merged; unused slots are zero.
  - word_valid <= 1; word_last <= pix_last.
  - acc <= 0; cnt <= 0.
- Latency: one cycle from the completing pixel's accept edge to word_valid high.
- Non-completing accept: slot merged into acc, cnt <= cnt+1, no output change.
- Output handshake: word_valid is cleared on word_valid && word_ready unless a new word completes on the same edge. In that case the new word is loaded and word_valid stays 1. Throughput is one pixel per cycle with word_ready held high.
- word_out and word_last are held stable while word_valid && !word_ready.
- Line-end flush: pix_last with cnt==0 produces a word containing a single pixel in slot 0.
- Mode 101 with pix_last: PPW=1 (OUT_W=32), so word_last is simply set.
- Reset (rst_n=0 at a clock edge, including mid-word or mid-stall):
  - word_out=0, word_valid=0, word_last=0.
  - acc=0, cnt=0, mode_q=3'b000.
  - Partial words are discarded.
  - pix_ready is 1 in the cycle after reset.
- No pixel is dropped or duplicated under any valid/ready pattern.

Test Plan:
- OUT_W=32, MSB_FIRST=0, mode 011, pixels 0x11,0x22,0x33,0x44 back-to-back, word_ready=1 -> one word 0x44332211, word_valid high for 1 cycle one cycle after the 4th accept, word_last=0.
- Mode 110, pixels 0xFF0000 then 0x00FF00, 2nd with pix_last -> word_out 0x07E0F800, word_last=1.
- Mode 000, 5 pixels with pix_in[0]=1, 5th pix_last -> word_out 0x0000001F, word_last=1, cnt back to 0.
- Mode 101, word_ready held 0 for 3 cycles after the first word -> pix_ready=0 during the stall, word_out=0x00ABCDEF held stable, second pixel accepted on the release cycle, no loss.
- Mode 100 word in progress; lcdbpp switched to 011 after 1 pixel -> 2nd pixel still encoded 1:5:5:5, mode_q=100 until the word emits, next word uses 011.
- MSB_FIRST=1, mode 010, 8 pixels 0x1..0x8; rst_n pulsed low after 3 pixels, then 8 fresh pixels -> the partial word is never emitted, output 0x12345678.
